mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - MEM-stage initiator for a variable-latency data memory: drives req/ready handshake for loads/stores.
// - Sits between EXE/MEM register outputs and the data memory; feeds mdo to MEM/WB.
// - Stalls the pipeline until the access completes, flags misaligned accesses and timeouts.
// PARAMETERS
// - TIMEOUT_CYC  8             max cycles in WAIT without mem_ready before abort (>=1)
// - ERR_DATA     32'hDEADBEEF  mdo value returned for a timed-out load
// PORTS
// - clk          in   1   single clock; all state updates on posedge
// - rst          in   1   asynchronous, active-high reset
// - m_valid      in   1   instruction present in MEM stage this cycle
// - mm2reg       in   1   MEM-stage instruction is a load
// - mwmem        in   1   MEM-stage instruction is a store
// - mr           in   32  ALU result = byte address (or result for non-memory ops)
// - mqb          in   32  store data
// - mem_req      out  1   request to data memory (registered)
// - mem_we       out  1   1 = write, 0 = read (registered, valid with mem_req)
// - mem_addr     out  32  word-aligned address (registered)
// - mem_wdata    out  32  write data (registered)
// - mem_ready    in   1   memory accepts/completes current request this cycle
// - mem_rdata    in   32  read data, valid when mem_ready & ~mem_we
// - stall        out  1   freeze PC, IF/ID, ID/EXE, EXE/MEM; MEM/WB holds bubble-free data only when 0
// - mdo          out  32  data to MEM/WB: load data, or mr for non-load ops
// - align_err    out  1   1-cycle pulse: access with mr[1:0] != 0, access suppressed
// - timeout_err  out  1   1-cycle pulse: request aborted after TIMEOUT_CYC
// BEHAVIOUR
// - Reset: state=IDLE; mem_req, mem_we, align_err, timeout_err = 0; mem_addr, mem_wdata, rdata_q, tcnt = 0.
// - acc = m_valid & (mm2reg | mwmem); mwmem has priority if both set (treated as store, mdo = mr).
// - FSM IDLE / WAIT / DONE:
//   IDLE: acc & mr[1:0]==0 -> WAIT; load mem_req<=1, mem_we<=mwmem, mem_addr<=mr, mem_wdata<=mqb,
//         tcnt<=0; stall=1 combinationally this cycle.
//         acc & mr[1:0]!=0 -> stay IDLE, align_err<=1 (visible next cycle, 1 cycle), stall=0, mdo=mr.
//         no acc -> stall=0, mdo=mr (combinational pass-through, zero latency).
//   WAIT: stall=1; mem_req/we/addr/wdata held stable until handshake.
//         mem_ready=1 -> capture rdata_q<=mem_rdata (loads), mem_req<=0, -> DONE.
//         mem_ready=0 & tcnt==TIMEOUT_CYC-1 -> mem_req<=0, rdata_q<=ERR_DATA, timeout_err<=1, -> DONE.
//         else tcnt<=tcnt+1 (width clog2(TIMEOUT_CYC+1), never wraps).
//   DONE: stall=0 for exactly 1 cycle; mdo = load ? rdata_q : mr; pipeline advances at end of cycle;
//         -> IDLE unconditionally (no new access may start in DONE).
// - Latency: ready in first WAIT cycle -> 2 stall cycles, data in 3rd cycle; each extra wait cycle adds 1.
// - mem_ready outside WAIT is ignored; late response after timeout is ignored.
// - Error pulses clear to 0 the following cycle; they never assert together.
// - rst mid-operation: all outputs to reset values immediately; request dropped, no data returned.
// TESTING
// - Load mr=0x08, mem_ready high in 2nd WAIT cycle with rdata=0x20000022 -> stall=1 cycles 0-2,
//   mem_req=1 cycles 1-2, mdo=0x20000022 with stall=0 in cycle 3.
// - Store mr=0x10, mqb=0x40000044, mem_ready immediate -> mem_req/mem_we=1 one cycle, addr 0x10,
//   wdata 0x40000044, stall=1 for 2 cycles, mdo=0x10 in DONE.
// - ALU op (m_valid=1, mm2reg=mwmem=0), mr=0x1234 -> stall=0, mem_req=0, mdo=0x1234 same cycle.
// - Load mr=0x06 -> align_err=1 for 1 cycle, mem_req never asserts, stall=0.
// - Load mr=0x20, mem_ready held 0 -> after 8 WAIT cycles mem_req=0, timeout_err pulse, mdo=0xDEADBEEF.
// - Assert rst in WAIT, then mem_ready=1 -> all outputs 0 immediately, FSM IDLE, response ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage initiator for a variable-latency data memory.
//               Issues load/store requests, stalls the pipeline until the
//               access completes, flags misaligned accesses and timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int          TIMEOUT_CYC = 8,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] mr,
    input  logic [31:0] mqb,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] mdo,
    output logic        align_err,
    output logic        timeout_err
);

    localparam int             c_TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [c_TW-1:0] r_tcnt;
    logic [31:0]     r_rdata;
    logic            r_is_load;

    logic w_acc;
    logic w_misal;
    logic w_start;
    logic w_hs;
    logic w_timeout;

    // A store wins when both load and store are flagged.
    assign w_acc     = m_valid & (mm2reg | mwmem);
    assign w_misal   = (mr[1:0] != 2'b00);
    assign w_start   = (r_state == c_IDLE) & w_acc & ~w_misal;
    assign w_hs      = (r_state == c_WAIT) & mem_ready;
    assign w_timeout = (r_state == c_WAIT) & ~mem_ready & (r_tcnt == c_TLAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_start) w_next = c_WAIT;
            c_WAIT:  if (w_hs || w_timeout) w_next = c_DONE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Reset forces the combinational outputs quiet as well as the registers.
    always_comb begin
        stall = 1'b0;
        mdo   = mr;
        case (r_state)
            c_IDLE:  stall = w_start;
            c_WAIT:  stall = 1'b1;
            c_DONE:  mdo   = r_is_load ? r_rdata : mr;
            default: stall = 1'b0;
        endcase
        if (rst) begin
            stall = 1'b0;
            mdo   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            align_err   <= 1'b0;
            timeout_err <= 1'b0;
            r_tcnt      <= '0;
            r_rdata     <= '0;
            r_is_load   <= 1'b0;
        end else begin
            align_err   <= (r_state == c_IDLE) & w_acc & w_misal;
            timeout_err <= w_timeout;
            if (w_start) begin
                mem_req   <= 1'b1;
                mem_we    <= mwmem;
                mem_addr  <= mr;
                mem_wdata <= mqb;
                r_tcnt    <= '0;
                r_is_load <= ~mwmem;
            end else if (w_hs) begin
                mem_req <= 1'b0;
                r_rdata <= mem_rdata;
            end else if (w_timeout) begin
                mem_req <= 1'b0;
                r_rdata <= ERR_DATA;
            end else if (r_state == c_WAIT) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed plus randomized transactions against a transaction-
//               level model of the MEM-stage access unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int          c_TO  = 8;
    localparam logic [31:0] c_ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid, mm2reg, mwmem;
    logic [31:0] mr, mqb;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] mdo;
    logic        align_err, timeout_err;

    int npass  = 0;
    int ntotal = 0;

    mem_access_unit #(.TIMEOUT_CYC(c_TO), .ERR_DATA(c_ERR)) dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .mm2reg(mm2reg), .mwmem(mwmem),
        .mr(mr), .mqb(mqb), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .stall(stall), .mdo(mdo),
        .align_err(align_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One MEM-stage instruction. delay = WAIT cycle index in which the memory
    // answers; any delay >= c_TO means the memory never answers.
    task automatic run_txn(input logic mv, input logic ld, input logic st,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rd, input int delay);
        logic        acc, mis, is_ld, to;
        int          waits;
        logic [31:0] exp_mdo;
        acc   = mv & (ld | st);
        mis   = (a % 4) != 0;
        is_ld = ld & ~st;
        to    = (delay >= c_TO);
        waits = to ? c_TO : delay + 1;
        exp_mdo = !is_ld ? a : (to ? c_ERR : rd);

        @(posedge clk); #1;
        m_valid = mv; mm2reg = ld; mwmem = st; mr = a; mqb = d;
        mem_ready = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        if (!acc || mis) begin
            chk("pass_stall", stall, 0);
            chk("pass_mdo", mdo, a);
            chk("pass_req", mem_req, 0);
            @(posedge clk); #1;
            m_valid = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("align_pulse", align_err, acc & mis);
            chk("pass_req_after", mem_req, 0);
            chk("pass_to", timeout_err, 0);
            @(posedge clk); #1;
            mem_ready = 1'b0;
            @(negedge clk);
            chk("align_clear", align_err, 0);
            return;
        end
        chk("start_stall", stall, 1);
        chk("start_req", mem_req, 0);
        for (int k = 0; k < waits; k++) begin
            @(posedge clk); #1;
            if (k == delay) begin
                mem_ready = 1'b1;
                mem_rdata = rd;
            end
            @(negedge clk);
            chk("wait_req", mem_req, 1);
            chk("wait_we", mem_we, st);
            chk("wait_addr", mem_addr, a);
            chk("wait_wdata", mem_wdata, d);
            chk("wait_stall", stall, 1);
            chk("wait_errs", {align_err, timeout_err}, 0);
        end
        @(posedge clk); #1;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(negedge clk);
        chk("done_stall", stall, 0);
        chk("done_req", mem_req, 0);
        chk("done_mdo", mdo, exp_mdo);
        chk("done_to", timeout_err, to);
        chk("done_align", align_err, 0);
        @(posedge clk); #1;
        m_valid = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("idle_stall", stall, 0);
        chk("idle_req", mem_req, 0);
        chk("idle_to", timeout_err, 0);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; m_valid = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
        mr = 32'h0; mqb = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_errs", {align_err, timeout_err}, 0);
        chk("rst_stall", stall, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn(1, 1, 0, 32'h08, 32'h0, 32'h20000022, 1);
        run_txn(1, 0, 1, 32'h10, 32'h40000044, 32'h0, 0);
        run_txn(1, 0, 0, 32'h1234, 32'h0, 32'h0, 0);
        run_txn(1, 1, 0, 32'h06, 32'h0, 32'h0, 0);
        run_txn(1, 1, 0, 32'h20, 32'h0, 32'h12345678, 100);
        run_txn(1, 1, 1, 32'h44, 32'hCAFEF00D, 32'h55555555, 3);
        run_txn(0, 1, 0, 32'h48, 32'h0, 32'h0, 0);
        run_txn(1, 1, 0, 32'h4C, 32'h0, 32'h0BADF00D, c_TO - 1);
        run_txn(1, 0, 1, 32'h53, 32'h1, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_txn(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), a, $urandom, $urandom,
                    int'($urandom_range(0, c_TO + 2)));
        end

        // Reset in the middle of a load, with a response arriving at the same time.
        @(posedge clk); #1;
        m_valid = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; mr = 32'h80; mqb = 32'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_req", mem_req, 1);
        #1;
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h11111111;
        #1;
        chk("midrst_req", mem_req, 0);
        chk("midrst_we", mem_we, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_wdata", mem_wdata, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_errs", {align_err, timeout_err}, 0);
        @(posedge clk); #1;
        m_valid = 1'b0; mm2reg = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("postrst_req", mem_req, 0);
        chk("postrst_stall", stall, 0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("postrst_idle_req", mem_req, 0);
        chk("postrst_errs", {align_err, timeout_err}, 0);
        chk("postrst_mdo", mdo, 32'h80);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
`default_nettype wire
